calculadora_seq: RTL and testbench
==================================

CALCULADORA_SEQ -- requirements
Module: calculadora_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand magnitude width in bits (legal range 2..16).
REQ-002 Parameter DEBOUNCE_EN, default 0, SHALL, when 1, require a button to be low for 2 consecutive clocks before its press is accepted.
REQ-003 clock  in  1  single clock; all state updates on posedge; reset is synchronous and active-low.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 button_enable, button_soma, button_subtracao, button_multiplicacao, button_divisao  in  1 each  active-low push-buttons; press = 1->0 transition.
REQ-006 sinal_a, sinal_b  in  1 each  operand signs (1 = negative).
REQ-007 a, b  in  WIDTH each  operand magnitudes (sign-magnitude).
REQ-008 sinal_s  out  1  result sign.
REQ-009 s  out  2*WIDTH  result magnitude (quotient for division).
REQ-010 resto  out  WIDTH  division remainder magnitude; 0 for other operations.
REQ-011 oper  out  3  current mode: DESLIGADO=0, ESPERANDO=1, SOMA=2, SUBTRACAO=3, MULTIPLICACAO=4, DIVISAO=5.
REQ-012 busy  out  1  high while a multi-cycle operation is in progress.
REQ-013 valid  out  1  one-cycle pulse when s/sinal_s/resto are updated.
REQ-014 div_zero  out  1  high when the last completed division had b == 0; cleared on next valid.

Function
REQ-015 Press detection SHALL register all five buttons each clock and flag a press when the registered value is 1 and the current (or debounced) value is 0.
REQ-016 Simultaneous presses SHALL resolve with priority enable > multiplicacao > divisao > subtracao > soma; lower-priority presses in that cycle are discarded.
REQ-017 Control FSM states: OFF, IDLE, CALC, DONE; oper = DESLIGADO in OFF, ESPERANDO in IDLE until the first operation is selected.
REQ-018 enable press: OFF -> IDLE; any other state -> OFF, aborting CALC, clearing s, resto, sinal_s, div_zero, busy, and emitting no valid.
REQ-019 Operation press in IDLE or DONE SHALL latch a, b, sinal_a, sinal_b, set oper, and enter CALC; operation presses in OFF or CALC are ignored.
REQ-020 SOMA/SUBTRACAO SHALL complete in CALC in 1 cycle: valid rises 2 clocks after the press edge is sampled.
REQ-021 MULTIPLICACAO SHALL use shift-add over WIDTH cycles; DIVISAO SHALL use restoring division over WIDTH cycles; valid rises WIDTH+1 clocks after the press is sampled; busy is high for exactly those WIDTH cycles.
REQ-022 SOMA: equal signs -> s = a+b, sign shared; differing signs -> s = |a-b|, sign of the larger magnitude (sinal_a on tie).
REQ-023 SUBTRACAO SHALL equal SOMA with sinal_b inverted.
REQ-024 MULTIPLICACAO: s = a*b (exact, 2*WIDTH bits), sinal_s = sinal_a XOR sinal_b.
REQ-025 DIVISAO: s = a/b zero-extended, resto = a mod b, sinal_s = sinal_a XOR sinal_b; truncation toward zero, remainder magnitude only.
REQ-026 b == 0 in DIVISAO: s = all ones (2*WIDTH), resto = a, sinal_s = 0, div_zero = 1, same latency as a normal division.
REQ-027 Any result with s == 0 SHALL force sinal_s = 0 (no negative zero).
REQ-028 Input changes during CALC SHALL NOT affect the result (latched operands only).
REQ-029 In DONE, outputs SHALL hold until the next operation completes, the mode is switched off, or reset.
REQ-030 Re-pressing the current operation button in DONE SHALL recompute with freshly latched operands.

Reset
REQ-031 reset_n low at a posedge SHALL set FSM = OFF, oper = DESLIGADO, s = 0, resto = 0, sinal_s = 0, busy = 0, valid = 0, div_zero = 0, button registers = all ones.
REQ-032 Reset asserted mid-CALC SHALL abort the operation with no valid pulse.
REQ-033 A button held low across reset release SHALL NOT register a press until released and pressed again.

Structure
REQ-034 A shared package SHALL hold the oper encoding constants and the FSM state type.
REQ-035 Multiply/divide datapath SHALL be one sub-module, calculadora_seq_muldiv (start, op, operands in; done, product/quotient, remainder out).

Verification (WIDTH=8)
REQ-036 enable press, then soma with a=5,sinal_a=1,b=9,sinal_b=0 -> 2 clocks later valid, s=4, sinal_s=0.
REQ-037 subtracao, a=7,b=7, both positive -> s=0, sinal_s=0, valid 2 clocks after press.
REQ-038 multiplicacao a=255,sinal_a=1,b=255,sinal_b=0 -> busy 8 clocks, valid at clock 9, s=65025, sinal_s=1.
REQ-039 divisao a=100,b=7,sinal_b=1 -> s=14, resto=2, sinal_s=1; repeat with b=0 -> s=16'hFFFF, resto=100, div_zero=1.
REQ-040 soma and multiplicacao pressed same cycle -> oper=MULTIPLICACAO; enable press during busy -> OFF, no valid, outputs 0.
REQ-041 reset_n low at clock 4 of a division -> all outputs at reset values next cycle, no valid pulse.

Source files
------------

// File: rtl/calculadora_seq_pkg.sv
// Shared definitions for the sequential sign-magnitude calculator: mode
// encoding, control FSM states, button indices and the add/subtract helper.
package calculadora_seq_pkg;

  localparam logic [2:0] OPER_DESLIGADO     = 3'd0;
  localparam logic [2:0] OPER_ESPERANDO     = 3'd1;
  localparam logic [2:0] OPER_SOMA          = 3'd2;
  localparam logic [2:0] OPER_SUBTRACAO     = 3'd3;
  localparam logic [2:0] OPER_MULTIPLICACAO = 3'd4;
  localparam logic [2:0] OPER_DIVISAO       = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_OFF  = 2'd0;
  localparam state_t ST_IDLE = 2'd1;
  localparam state_t ST_CALC = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int BTN_SOMA   = 0;
  localparam int BTN_SUB    = 1;
  localparam int BTN_MUL    = 2;
  localparam int BTN_DIV    = 3;
  localparam int BTN_ENABLE = 4;

  localparam int MAX_WIDTH = 16;

  typedef struct packed {
    logic                 sign;
    logic [MAX_WIDTH:0]   mag;
  } sm_result_t;

  // Sign-magnitude addition; a zero result is always reported as positive.
  function automatic sm_result_t smAdd(input logic [MAX_WIDTH-1:0] magA,
                                       input logic                 signA,
                                       input logic [MAX_WIDTH-1:0] magB,
                                       input logic                 signB);
    sm_result_t res;
    if (signA == signB) begin
      res.mag  = {1'b0, magA} + {1'b0, magB};
      res.sign = signA;
    end else if (magA >= magB) begin
      res.mag  = {1'b0, magA - magB};
      res.sign = signA;
    end else begin
      res.mag  = {1'b0, magB - magA};
      res.sign = signB;
    end
    if (res.mag == '0) res.sign = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/calculadora_seq_muldiv.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one step per clock for WIDTH clocks after a start pulse.
module calculadora_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_op,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_result,
  output logic [WIDTH-1:0]     o_rem
);

  localparam int CW = 5;

  logic [CW-1:0]      r_cnt;
  logic               r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;

  logic [2*WIDTH-1:0] w_acc;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo;

  // Next-step values are exposed directly so the final step's result is
  // available on the same edge that completes it.
  always_comb begin
    w_acc     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_shifted = {r_rem, r_quo[WIDTH-1]};
    w_trial   = w_shifted - {1'b0, r_div};
    if (!w_trial[WIDTH]) begin
      w_rem = w_trial[WIDTH-1:0];
      w_quo = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem = w_shifted[WIDTH-1:0];
      w_quo = {r_quo[WIDTH-2:0], 1'b0};
    end
    o_done   = (r_cnt == CW'(1));
    o_result = r_op ? {{WIDTH{1'b0}}, w_quo} : w_acc;
    o_rem    = r_op ? w_rem : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
    end else if (i_start) begin
      r_cnt    <= CW'(WIDTH);
      r_op     <= i_op;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_rem    <= '0;
      r_quo    <= i_a;
      r_div    <= i_b;
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - CW'(1);
      r_acc    <= w_acc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_rem    <= w_rem;
      r_quo    <= w_quo;
    end
  end

endmodule

// File: rtl/calculadora_seq.sv
// Sequential sign-magnitude calculator driven by active-low push-buttons;
// add/subtract finish in one CALC cycle, multiply/divide in WIDTH cycles.
module calculadora_seq
  import calculadora_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit DEBOUNCE_EN = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 button_enable,
  input  logic                 button_soma,
  input  logic                 button_subtracao,
  input  logic                 button_multiplicacao,
  input  logic                 button_divisao,
  input  logic                 sinal_a,
  input  logic                 sinal_b,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 sinal_s,
  output logic [2*WIDTH-1:0]   s,
  output logic [WIDTH-1:0]     resto,
  output logic [2:0]           oper,
  output logic                 busy,
  output logic                 valid,
  output logic                 div_zero
);

  logic [4:0] w_btnIn;
  logic [4:0] w_deb;
  logic [4:0] w_pressNow;
  logic [4:0] r_btnPrev;
  logic [4:0] r_btnReg;
  logic [4:0] r_armed;
  logic [4:0] r_press;

  // A button only counts once it has been seen released since reset, so a
  // key held through reset release cannot fire.
  always_comb begin
    w_btnIn    = {button_enable, button_divisao, button_multiplicacao,
                  button_subtracao, button_soma};
    w_deb      = w_btnIn | (r_btnPrev & {5{DEBOUNCE_EN}});
    w_pressNow = r_btnReg & ~w_deb & r_armed;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_btnPrev <= '1;
      r_btnReg  <= '1;
      r_armed   <= '0;
      r_press   <= '0;
    end else begin
      r_btnPrev <= w_btnIn;
      r_btnReg  <= w_deb;
      r_armed   <= r_armed | w_deb;
      r_press   <= w_pressNow;
    end
  end

  state_t             r_state;
  logic [2:0]         r_oper;
  logic [2*WIDTH-1:0] r_s;
  logic [WIDTH-1:0]   r_resto;
  logic               r_sinalS;
  logic               r_busy;
  logic               r_valid;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signA;
  logic               r_signB;

  logic               w_enPress;
  logic [2:0]         w_selOp;
  logic               w_opReq;
  logic               w_mdStart;
  logic               w_mdOp;
  logic               w_mdDone;
  logic [2*WIDTH-1:0] w_mdResult;
  logic [WIDTH-1:0]   w_mdRem;
  sm_result_t         w_addRes;
  logic [2*WIDTH-1:0] w_addS;
  logic [2*WIDTH-1:0] w_mdS;
  logic [WIDTH-1:0]   w_mdResto;
  logic               w_mdSign;
  logic               w_mdDz;

  // Priority: enable > multiplicacao > divisao > subtracao > soma.
  always_comb begin
    w_enPress = r_press[BTN_ENABLE];
    w_selOp   = OPER_DESLIGADO;
    if (r_press[BTN_MUL])       w_selOp = OPER_MULTIPLICACAO;
    else if (r_press[BTN_DIV])  w_selOp = OPER_DIVISAO;
    else if (r_press[BTN_SUB])  w_selOp = OPER_SUBTRACAO;
    else if (r_press[BTN_SOMA]) w_selOp = OPER_SOMA;
    w_opReq   = (w_selOp != OPER_DESLIGADO);
    w_mdOp    = (w_selOp == OPER_DIVISAO);
    w_mdStart = !w_enPress && w_opReq
                && (r_state == ST_IDLE || r_state == ST_DONE)
                && (w_selOp == OPER_MULTIPLICACAO || w_selOp == OPER_DIVISAO);
  end

  calculadora_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .i_clk    (clock),
    .i_rst_n  (reset_n),
    .i_start  (w_mdStart),
    .i_op     (w_mdOp),
    .i_a      (a),
    .i_b      (b),
    .o_done   (w_mdDone),
    .o_result (w_mdResult),
    .o_rem    (w_mdRem)
  );

  // Subtraction reuses the adder with the second sign flipped.
  always_comb begin
    w_addRes = smAdd(MAX_WIDTH'(r_a), r_signA, MAX_WIDTH'(r_b),
                     (r_oper == OPER_SUBTRACAO) ? ~r_signB : r_signB);
    w_addS   = (2*WIDTH)'(w_addRes.mag);
    if (r_oper == OPER_DIVISAO && r_b == '0) begin
      w_mdS     = '1;
      w_mdResto = r_a;
      w_mdSign  = 1'b0;
      w_mdDz    = 1'b1;
    end else begin
      w_mdS     = w_mdResult;
      w_mdResto = w_mdRem;
      w_mdSign  = (r_signA ^ r_signB) && (w_mdResult != '0);
      w_mdDz    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= ST_OFF;
      r_oper    <= OPER_DESLIGADO;
      r_s       <= '0;
      r_resto   <= '0;
      r_sinalS  <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_divZero <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_signA   <= 1'b0;
      r_signB   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_enPress) begin
        if (r_state == ST_OFF) begin
          r_state <= ST_IDLE;
          r_oper  <= OPER_ESPERANDO;
        end else begin
          r_state   <= ST_OFF;
          r_oper    <= OPER_DESLIGADO;
          r_s       <= '0;
          r_resto   <= '0;
          r_sinalS  <= 1'b0;
          r_divZero <= 1'b0;
          r_busy    <= 1'b0;
        end
      end else if (r_state == ST_CALC) begin
        if (!r_busy) begin
          r_s       <= w_addS;
          r_sinalS  <= w_addRes.sign;
          r_resto   <= '0;
          r_divZero <= 1'b0;
          r_valid   <= 1'b1;
          r_state   <= ST_DONE;
        end else if (w_mdDone) begin
          r_s       <= w_mdS;
          r_sinalS  <= w_mdSign;
          r_resto   <= w_mdResto;
          r_divZero <= w_mdDz;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_DONE;
        end
      end else if (r_state != ST_OFF && w_opReq) begin
        r_a     <= a;
        r_b     <= b;
        r_signA <= sinal_a;
        r_signB <= sinal_b;
        r_oper  <= w_selOp;
        r_busy  <= w_mdStart;
        r_state <= ST_CALC;
      end
    end
  end

  assign sinal_s  = r_sinalS;
  assign s        = r_s;
  assign resto    = r_resto;
  assign oper     = r_oper;
  assign busy     = r_busy;
  assign valid    = r_valid;
  assign div_zero = r_divZero;

endmodule

// File: tb/tb_calculadora_seq.sv
// Self-checking bench for calculadora_seq: fixed vectors, randomized
// operations against a signed-arithmetic model, and control corner cases.
module tb_calculadora_seq;

  localparam int W       = 8;
  localparam int OP_SOMA = 2;
  localparam int OP_SUB  = 3;
  localparam int OP_MUL  = 4;
  localparam int OP_DIV  = 5;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [4:0]       btn;
  logic             sinal_a, sinal_b;
  logic [W-1:0]     a, b;
  logic             sinal_s;
  logic [2*W-1:0]   s;
  logic [W-1:0]     resto;
  logic [2:0]       oper;
  logic             busy, valid, div_zero;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  calculadora_seq #(.WIDTH(W), .DEBOUNCE_EN(1'b0)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .button_enable        (btn[4]),
    .button_soma          (btn[0]),
    .button_subtracao     (btn[1]),
    .button_multiplicacao (btn[2]),
    .button_divisao       (btn[3]),
    .sinal_a              (sinal_a),
    .sinal_b              (sinal_b),
    .a                    (a),
    .b                    (b),
    .sinal_s              (sinal_s),
    .s                    (s),
    .resto                (resto),
    .oper                 (oper),
    .busy                 (busy),
    .valid                (valid),
    .div_zero             (div_zero)
  );

  typedef struct {
    int op; bit sa; int av; bit sb; int bv;
    int expS; bit expSign; int expResto; bit expDz;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Signed-integer reference: results derived from the values the
  // sign-magnitude operands represent.
  function automatic void refModel(input int op, input bit sa, input int av,
                                   input bit sb, input int bv,
                                   output int rs, output bit rsign,
                                   output int rresto, output bit rdz);
    int va, vb, r;
    va = sa ? -av : av;
    vb = sb ? -bv : bv;
    rresto = 0;
    rdz    = 1'b0;
    if (op == OP_DIV) begin
      if (bv == 0) begin
        rs = (1 << (2*W)) - 1; rsign = 1'b0; rresto = av; rdz = 1'b1;
      end else begin
        rs = av / bv; rresto = av % bv; rsign = (sa ^ sb) && (rs != 0);
      end
    end else begin
      if (op == OP_SOMA)     r = va + vb;
      else if (op == OP_SUB) r = va - vb;
      else                   r = va * vb;
      rs    = (r < 0) ? -r : r;
      rsign = (r < 0);
    end
  endfunction

  task automatic pressButtons(input logic [4:0] mask);
    @(negedge clock);
    btn = btn & ~mask;
    @(negedge clock);
    btn = '1;
  endtask

  task automatic applyStimulus(input string name, input int op,
                               input bit sa, input int av,
                               input bit sb, input int bv,
                               input int expS, input bit expSign,
                               input int expResto, input bit expDz);
    int lat, busyCnt, expLat, expBusy;
    logic [4:0] m;
    @(negedge clock);
    sinal_a = sa; a = W'(av); sinal_b = sb; b = W'(bv);
    m = '0;
    m[op-2] = 1'b1;
    pressButtons(m);
    lat = 0;
    busyCnt = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clock);
      if (valid) lat = c;
      else if (busy) busyCnt++;
      if (c == 1) begin
        a = W'($urandom); b = W'($urandom);
        sinal_a = $urandom_range(0, 1); sinal_b = $urandom_range(0, 1);
      end
    end
    expLat  = (op >= OP_MUL) ? W + 1 : 2;
    expBusy = (op >= OP_MUL) ? W : 0;
    checkOutput({name, "_latency"}, lat, expLat);
    checkOutput({name, "_busy"}, busyCnt, expBusy);
    checkOutput({name, "_s"}, s, expS);
    checkOutput({name, "_sign"}, sinal_s, expSign);
    checkOutput({name, "_resto"}, resto, expResto);
    checkOutput({name, "_divzero"}, div_zero, expDz);
    checkOutput({name, "_oper"}, oper, op);
    @(negedge clock);
    checkOutput({name, "_pulse"}, valid, 0);
  endtask

  initial begin
    int rs, rresto, op, av, bv, got, saw;
    bit rsign, rdz, sa, sb;

    vecs[0]  = '{OP_SOMA, 1, 5,   0, 9,   4,     0, 0,   0};
    vecs[1]  = '{OP_SUB,  0, 7,   0, 7,   0,     0, 0,   0};
    vecs[2]  = '{OP_MUL,  1, 255, 0, 255, 65025, 1, 0,   0};
    vecs[3]  = '{OP_DIV,  0, 100, 1, 7,   14,    1, 2,   0};
    vecs[4]  = '{OP_DIV,  0, 100, 1, 0,   65535, 0, 100, 1};
    vecs[5]  = '{OP_SOMA, 0, 200, 0, 100, 300,   0, 0,   0};
    vecs[6]  = '{OP_SUB,  0, 3,   0, 10,  7,     1, 0,   0};
    vecs[7]  = '{OP_SUB,  1, 5,   1, 5,   0,     0, 0,   0};
    vecs[8]  = '{OP_DIV,  1, 5,   0, 9,   0,     0, 5,   0};
    vecs[9]  = '{OP_MUL,  0, 0,   1, 77,  0,     0, 0,   0};
    vecs[10] = '{OP_SOMA, 1, 100, 1, 50,  150,   1, 0,   0};
    vecs[11] = '{OP_SOMA, 0, 5,   1, 9,   4,     1, 0,   0};
    vecs[12] = '{OP_SUB,  1, 20,  0, 30,  50,    1, 0,   0};
    vecs[13] = '{OP_MUL,  1, 16,  1, 16,  256,   0, 0,   0};
    vecs[14] = '{OP_DIV,  1, 255, 1, 1,   255,   0, 0,   0};
    vecs[15] = '{OP_SOMA, 0, 255, 0, 255, 510,   0, 0,   0};

    btn = '1;
    btn[4] = 1'b0;
    reset_n = 1'b0;
    sinal_a = 1'b0; sinal_b = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_oper", oper, 0);
    checkOutput("reset_s", s, 0);
    checkOutput("reset_resto", resto, 0);
    checkOutput("reset_sign", sinal_s, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_divzero", div_zero, 0);

    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("held_enable_no_press", oper, 0);
    btn[4] = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("release_no_press", oper, 0);
    pressButtons(5'b10000);
    @(negedge clock);
    checkOutput("enable_to_idle", oper, 1);

    for (int i = 0; i < 16; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].sa,
                    vecs[i].av, vecs[i].sb, vecs[i].bv, vecs[i].expS,
                    vecs[i].expSign, vecs[i].expResto, vecs[i].expDz);

    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(OP_SOMA, OP_DIV);
      sa = $urandom_range(0, 1);
      sb = $urandom_range(0, 1);
      av = $urandom_range(0, 255);
      bv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      refModel(op, sa, av, sb, bv, rs, rsign, rresto, rdz);
      applyStimulus($sformatf("rand%0d", i), op, sa, av, sb, bv,
                    rs, rsign, rresto, rdz);
    end

    @(negedge clock);
    a = 8'd12; b = 8'd11; sinal_a = 1'b0; sinal_b = 1'b0;
    pressButtons(5'b00101);
    @(negedge clock);
    checkOutput("simul_oper", oper, OP_MUL);
    checkOutput("simul_busy", busy, 1);
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clock);
      if (valid) got = 1;
    end
    checkOutput("simul_valid", got, 1);
    checkOutput("simul_s", s, 132);

    @(negedge clock);
    a = 8'd20; b = 8'd30;
    pressButtons(5'b00100);
    @(negedge clock);
    pressButtons(5'b00001);
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clock);
      if (valid) got = 1;
    end
    checkOutput("calc_ignore_valid", got, 1);
    checkOutput("calc_ignore_s", s, 600);
    checkOutput("calc_ignore_oper", oper, OP_MUL);

    applyStimulus("div0_pre", OP_DIV, 1'b0, 77, 1'b0, 0, 65535, 1'b0, 77, 1'b1);
    @(negedge clock);
    a = 8'd200; b = 8'd3;
    pressButtons(5'b01000);
    repeat (3) @(negedge clock);
    pressButtons(5'b10000);
    saw = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (valid) saw = 1;
    end
    checkOutput("abort_no_valid", saw, 0);
    checkOutput("abort_oper", oper, 0);
    checkOutput("abort_s", s, 0);
    checkOutput("abort_resto", resto, 0);
    checkOutput("abort_sign", sinal_s, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_divzero", div_zero, 0);

    pressButtons(5'b00001);
    repeat (3) @(negedge clock);
    checkOutput("off_ignore_oper", oper, 0);
    pressButtons(5'b10000);
    @(negedge clock);
    checkOutput("reenable_oper", oper, 1);

    applyStimulus("pre_reset", OP_DIV, 1'b0, 100, 1'b1, 7, 14, 1'b1, 2, 1'b0);
    @(negedge clock);
    a = 8'd50; b = 8'd3;
    pressButtons(5'b01000);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    checkOutput("midreset_oper", oper, 0);
    checkOutput("midreset_s", s, 0);
    checkOutput("midreset_resto", resto, 0);
    checkOutput("midreset_sign", sinal_s, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_valid", valid, 0);
    checkOutput("midreset_divzero", div_zero, 0);
    @(negedge clock);
    reset_n = 1'b1;
    saw = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (valid) saw = 1;
    end
    checkOutput("midreset_no_valid", saw, 0);
    checkOutput("midreset_stays_off", oper, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
